// File: rtl/fsm_trace_if.sv
// Sample/result bundle between the monitored FSM output and fsm_trace_checker.
interface fsm_trace_if #(parameter int CW = 8);
  logic          en;
  logic          a;
  logic [2:0]    code;
  logic          clr;
  logic          err;
  logic          err_sticky;
  logic [2:0]    err_code;
  logic [2:0]    err_prev;
  logic [CW-1:0] loop_cnt;

  modport master (
    output en, a, code, clr,
    input  err, err_sticky, err_code, err_prev, loop_cnt
  );

  modport slave (
    input  en, a, code, clr,
    output err, err_sticky, err_code, err_prev, loop_cnt
  );
endinterface

// File: rtl/fsm_trace_checker.sv
// Checks every sampled code against the 5-code transition graph, captures the
// first error since clear and counts completed 0->3->5->0 loops.
module fsm_trace_checker #(
  parameter int CW = 8
) (
  input  logic        clk,
  input  logic        reset,
  fsm_trace_if.slave  bus
);

  // state    | meaning
  // TRK_IDLE | no prediction; next legal code only primes prev/exp
  // TRK_RUN  | prev_q holds last code, exp_q = next(prev, a_prev)
  // LP_N     | no loop prefix seen
  // LP_0/3/5 | loop prefix 0, 0-3, 0-3-5 seen
  typedef enum logic {TRK_IDLE, TRK_RUN} trk_e;
  typedef enum logic [1:0] {LP_N, LP_0, LP_3, LP_5} lp_e;

  trk_e          trk_q, trk_d;
  lp_e           lp_q, lp_d;
  logic [2:0]    prev_q, prev_d;
  logic [2:0]    exp_q, exp_d;
  logic          err_q, err_d;
  logic          sticky_q, sticky_d;
  logic [2:0]    ecode_q, ecode_d;
  logic [2:0]    eprev_q, eprev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          legal;
  logic          err_hit;

  function automatic logic [2:0] next_code(input logic [2:0] c, input logic a);
    case (c)
      3'd0:    return a ? 3'd4 : 3'd3;
      3'd3:    return a ? 3'd5 : 3'd2;
      3'd4:    return a ? 3'd3 : 3'd0;
      3'd2:    return 3'd4;
      3'd5:    return a ? 3'd2 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  always_comb begin
    trk_d   = trk_q;
    lp_d    = lp_q;
    prev_d  = prev_q;
    exp_d   = exp_q;
    err_d   = 1'b0;
    err_hit = 1'b0;
    legal   = 1'b0;
    // clear is applied first so a same-edge error/loop lands on clean captures
    sticky_d = bus.clr ? 1'b0 : sticky_q;
    ecode_d  = bus.clr ? 3'd0 : ecode_q;
    eprev_d  = bus.clr ? 3'd0 : eprev_q;
    cnt_d    = bus.clr ? '0 : cnt_q;

    if (bus.en) begin
      legal = (bus.code inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd5});
      if (!legal) begin
        err_hit = 1'b1;
        trk_d   = TRK_IDLE;
      end else begin
        if (trk_q == TRK_RUN && bus.code != exp_q) err_hit = 1'b1;
        trk_d  = TRK_RUN;
        prev_d = bus.code;
        exp_d  = next_code(bus.code, bus.a);
      end

      if (bus.code == 3'd0) begin
        lp_d = LP_0;
        if (lp_q == LP_5 && cnt_d != {CW{1'b1}}) cnt_d = cnt_d + CW'(1);
      end else if (bus.code == 3'd3 && lp_q == LP_0) begin
        lp_d = LP_3;
      end else if (bus.code == 3'd5 && lp_q == LP_3) begin
        lp_d = LP_5;
      end else begin
        lp_d = LP_N;
      end
    end else begin
      trk_d = TRK_IDLE;
      lp_d  = LP_N;
    end

    if (err_hit) begin
      err_d = 1'b1;
      if (!sticky_d) begin
        ecode_d = bus.code;
        eprev_d = (trk_q == TRK_RUN) ? prev_q : 3'd0;
      end
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_q    <= TRK_IDLE;
      lp_q     <= LP_N;
      prev_q   <= 3'd0;
      exp_q    <= 3'd0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      ecode_q  <= 3'd0;
      eprev_q  <= 3'd0;
      cnt_q    <= '0;
    end else begin
      trk_q    <= trk_d;
      lp_q     <= lp_d;
      prev_q   <= prev_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      ecode_q  <= ecode_d;
      eprev_q  <= eprev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.err_code   = ecode_q;
  assign bus.err_prev   = eprev_q;
  assign bus.loop_cnt   = cnt_q;

endmodule

// File: tb/tb_fsm_trace_checker.sv
// Vector/scoreboard bench for fsm_trace_checker; a CW=2 copy shares the stimulus.
module tb_fsm_trace_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fsm_trace_if #(.CW(8)) bus8();
  fsm_trace_if #(.CW(2)) bus2();

  assign bus2.en   = bus8.en;
  assign bus2.a    = bus8.a;
  assign bus2.code = bus8.code;
  assign bus2.clr  = bus8.clr;

  fsm_trace_checker #(.CW(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
  fsm_trace_checker #(.CW(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  typedef struct {
    logic       en;
    logic       a;
    logic [2:0] code;
    logic       clr;
    logic       err;
    logic       sticky;
    logic [2:0] ecode;
    logic [2:0] eprev;
    logic [7:0] cnt;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;
  int step_no = 0;
  vec_t sb[$];
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic a, input logic [2:0] code,
                              input logic clr, input logic err, input logic sticky,
                              input logic [2:0] ecode, input logic [2:0] eprev,
                              input logic [7:0] cnt);
    vec_t v;
    v.en = en; v.a = a; v.code = code; v.clr = clr;
    v.err = err; v.sticky = sticky; v.ecode = ecode; v.eprev = eprev; v.cnt = cnt;
    return v;
  endfunction

  task automatic check_all(input string tag, input vec_t e);
    logic [7:0] cnt2;
    cnt2 = (e.cnt > 8'd3) ? 8'd3 : e.cnt;
    chk({tag, " err"},        32'(bus8.err),        32'(e.err));
    chk({tag, " err_sticky"}, 32'(bus8.err_sticky), 32'(e.sticky));
    chk({tag, " err_code"},   32'(bus8.err_code),   32'(e.ecode));
    chk({tag, " err_prev"},   32'(bus8.err_prev),   32'(e.eprev));
    chk({tag, " loop_cnt"},   32'(bus8.loop_cnt),   32'(e.cnt));
    chk({tag, " loop_cnt_cw2"}, 32'(bus2.loop_cnt), 32'(cnt2));
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    bus8.en   = v.en;
    bus8.a    = v.a;
    bus8.code = v.code;
    bus8.clr  = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    step_no++;
    check_all($sformatf("s%0d", step_no), e);
  endtask

  initial begin
    bus8.en = 1'b0; bus8.a = 1'b0; bus8.code = 3'd0; bus8.clr = 1'b0;

    // legal walk 0,3,2,4,0,3,2 with a=0
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,3,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,2,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,4,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,3,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,2,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,0));
    // two full loops
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,1,3,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,5,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(1,1,3,0, 0,0,0,0,1));
    tbl.push_back(mk(1,0,5,0, 0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,2));
    // wrong transition, then illegal codes back to back
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,2));
    tbl.push_back(mk(1,0,3,0, 0,0,0,0,2));
    tbl.push_back(mk(1,0,4,0, 1,1,4,3,2));
    tbl.push_back(mk(1,0,0,0, 0,1,4,3,2));
    tbl.push_back(mk(1,0,3,0, 0,1,4,3,2));
    tbl.push_back(mk(1,0,7,0, 1,1,4,3,2));
    tbl.push_back(mk(1,0,1,0, 1,1,4,3,2));
    tbl.push_back(mk(1,0,2,0, 0,1,4,3,2));
    // clear together with an error: new error becomes the first one
    tbl.push_back(mk(1,1,3,1, 1,1,3,2,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", mk(0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // enable gap drops prediction: 4 after 3(a=1) is not an error
    step(mk(1,0,0,0, 0,0,0,0,0));
    step(mk(1,1,3,0, 0,0,0,0,0));
    for (int i = 0; i < 3; i++) step(mk(0,0,0,0, 0,0,0,0,0));
    step(mk(1,0,4,0, 0,0,0,0,0));
    step(mk(1,0,0,0, 0,0,0,0,0));
    step(mk(1,0,4,0, 1,1,4,0,0));

    // asynchronous reset mid-run
    @(negedge clk);
    bus8.en = 1'b0;
    #2 reset = 1'b1;
    #1 check_all("async_reset", mk(0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    reset = 1'b0;

    // illegal first sample after reset, then re-prime
    step(mk(1,0,7,0, 1,1,7,0,0));
    step(mk(1,0,2,0, 0,1,7,0,0));
    step(mk(1,0,4,0, 0,1,7,0,0));

    // five loops: CW=2 copy saturates at 3
    step(mk(1,0,0,0, 0,1,7,0,0));
    for (int k = 1; k <= 5; k++) begin
      step(mk(1,1,3,0, 0,1,7,0,8'(k-1)));
      step(mk(1,0,5,0, 0,1,7,0,8'(k-1)));
      step(mk(1,0,0,0, 0,1,7,0,8'(k)));
    end
    // clear on the closing edge of a loop
    step(mk(1,1,3,0, 0,1,7,0,5));
    step(mk(1,0,5,0, 0,1,7,0,5));
    step(mk(1,0,0,1, 0,0,0,0,1));
    // illegal code from IDLE captures prev 0 even though last code was 3
    step(mk(1,1,3,0, 0,0,0,0,1));
    step(mk(0,0,0,0, 0,0,0,0,1));
    step(mk(1,0,6,0, 1,1,6,0,1));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
